lock_arbiter: RTL and testbench
===============================

# lock_arbiter

Round-robin arbiter with locked (held) grants for sharing one resource among N requesters. A requester, once granted, owns the resource until it signals `done` or drops its `req`. Ownership then hands over to the next requester in rotation with no idle cycle. It is the sequencing layer above the plain per-cycle round-robin arbiter, used where a transaction spans multiple cycles.

## Interface
- `N`, default 4: number of requesters; N ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles when timeout is compiled in; MAX_HOLD ≥ 2.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, N: request vector, level-sensitive.
- `done`, input, N: release pulse; only the bit of the current owner is honoured.
- `grant`, output, N: registered, one-hot or zero.
- `grant_id`, output, $clog2(N): index of the current owner; 0 when idle.
- `busy`, output, 1: high while any grant is asserted.
- `timeout`, output, 1: one-cycle pulse on a forced release.

## Operation
- State machine has two states, IDLE and GRANT. Internal state:
  - `last` pointer, $clog2(N) bits, holding the index of the most recent winner.
  - Hold counter, $clog2(MAX_HOLD) bits.
- Winner selection:
  - Search indices last+1, last+2, … modulo N, wrapping past N-1 to 0.
  - The first asserted request wins.
  - The owner's own bit is searched last, so it loses to any other requester.
- IDLE:
  - If req ≠ 0, register `grant` = one-hot winner, `grant_id` = winner, `last` = winner, counter = 0, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, release condition = `done[grant_id]` OR NOT `req[grant_id]` OR forced timeout.
  - No release: hold `grant`, `grant_id` and `last`; counter increments.
  - Release: arbitrate over req with the owner bit masked to 0.
    - Winner exists: load the new grant in the same edge, counter = 0, stay in GRANT. This is a zero-bubble handover.
    - No winner: `grant` = 0, `grant_id` = 0, go to IDLE.
- Any `done` bit other than the owner's is ignored in every state.
- `busy` = OR of `grant`. It is registered alongside `grant`.

## Timing
- Reset values:
  - `grant` = 0, `grant_id` = 0, `busy` = 0, `timeout` = 0.
  - State = IDLE, counter = 0.
  - `last` = N-1, so index 0 has first priority after reset.
- Request-to-grant latency in IDLE: 1 cycle. `req` sampled at edge k gives `grant` visible after edge k.
- Release sampled at edge k: the grant changes or clears after edge k. The owner sees its grant drop in the cycle after its `done` pulse.
- A requester released without a competitor, whose `req` is still high, is re-granted via IDLE after a one-cycle gap.
- Simultaneous release and new requests: new requests arriving in the release cycle take part in that same arbitration.
- `reset` asserted mid-grant: all outputs are 0 after that edge and no `timeout` pulse occurs. `reset` has priority over every other event.

## Configuration
- `LOCK_ARB_TIMEOUT_EN` defined:
  - The counter is compiled in.
  - At an edge where counter == MAX_HOLD-1 and no other release condition holds, a forced release occurs, so the grant is held exactly MAX_HOLD cycles.
  - `timeout` is high for the one cycle following that edge.
  - If another release condition coincides with the forced release, `timeout` stays 0.
- `LOCK_ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A grant is held indefinitely until `done` or `req` drop.

## Test plan
- Default parameters: N=4, MAX_HOLD=8.
- Reset then req=1111 -> grant=0001, grant_id=0, busy=1 one cycle after req is first sampled.
- req=1111 held, owner pulses `done` one cycle after each new grant -> grant sequence 0001, 0010, 0100, 1000, 0001 with no zero cycle between grants.
- Owner 0 with req=0011, then req drops to 0010 -> next edge grant=0010. Then req=0000 -> grant=0000, busy=0.
- Owner 2 (grant=0100), done=1011 pulsed -> grant stays 0100. Then done=0100 with req=1111 -> grant=1000.
- Macro defined, req=0001 constant, no done -> grant=0001 for exactly 8 cycles, timeout pulses 1 cycle, grant=0000 for 1 cycle, then 0001 again. Macro undefined -> grant=0001 for 20+ cycles, timeout always 0.
- Owner 3 (grant=1000), reset high for 1 cycle -> all outputs 0. Then req=1010 -> grant=0010, because `last` reset to 3 so index 0 is searched first and index 1 is the first asserted bit.

Source files
------------

// File: rtl/lock_arbiter.sv
// Round-robin arbiter with locked grants: an owner keeps the resource until done or req drop.
// Optional hold-time limit with forced release is compiled in with LOCK_ARB_TIMEOUT_EN.
module lock_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned IW = $clog2(N);

  if (N < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("lock_arbiter: N and MAX_HOLD must both be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, next_state;
  logic [IW-1:0]   last, last_d;
  logic [IW-1:0]   grant_id_d;
  logic [N-1:0]    grant_d;
  logic            busy_d;
  logic            timeout_d;
  logic [N-1:0]    arb_req;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            owner_rel;
  logic            forced;

`ifdef LOCK_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt, cnt_d;
`endif

  // Rotating search from last+1; on release the owner is masked so it cannot re-win
  always_comb begin
    int unsigned j;
    logic [IW-1:0] idx;
    j         = 0;
    idx       = '0;
    arb_req   = req;
    win_found = 1'b0;
    win_idx   = '0;
    if (state == GRANT) arb_req[grant_id] = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      j   = (32'(last) + i) % N;
      idx = IW'(j);
      if (!win_found && arb_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign owner_rel = done[grant_id] | ~req[grant_id];

`ifdef LOCK_ARB_TIMEOUT_EN
  assign forced = (cnt == CW'(MAX_HOLD - 1)) & ~owner_rel;
`else
  assign forced = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    next_state = state;
    grant_d    = grant;
    grant_id_d = grant_id;
    last_d     = last;
    timeout_d  = 1'b0;
`ifdef LOCK_ARB_TIMEOUT_EN
    cnt_d      = cnt + CW'(1);
`endif
    case (state)
      IDLE: begin
`ifdef LOCK_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_id_d       = win_idx;
          last_d           = win_idx;
          next_state       = GRANT;
        end
      end
      GRANT: begin
        if (owner_rel || forced) begin
          timeout_d = forced;
`ifdef LOCK_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            grant_id_d       = win_idx;
            last_d           = win_idx;
          end else begin
            grant_d    = '0;
            grant_id_d = '0;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      last     <= IW'(N - 1);
`ifdef LOCK_ARB_TIMEOUT_EN
      cnt      <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      last     <= last_d;
`ifdef LOCK_ARB_TIMEOUT_EN
      cnt      <= cnt_d;
      timeout  <= timeout_d;
`endif
    end
  end

`ifndef LOCK_ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lock_arbiter.sv
// Directed bench for lock_arbiter: vector table plus hold-limit and release sequences.
module tb_lock_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  g;
    logic [IW-1:0] id;
    logic          b;
    logic          t;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  lock_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [N-1:0] rq, logic [N-1:0] d,
                              logic [N-1:0] g, logic [IW-1:0] id, logic b, logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.id = id; v.b = b; v.t = t;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [N-1:0] g,
                           input logic [IW-1:0] id, input logic b, input logic t);
    chk({tag, ".grant"},    idx, 8'(grant),    8'(g));
    chk({tag, ".grant_id"}, idx, 8'(grant_id), 8'(id));
    chk({tag, ".busy"},     idx, 8'(busy),     8'(b));
    chk({tag, ".timeout"},  idx, 8'(timeout),  8'(t));
  endtask

  // Apply inputs, clock one edge, settle before sampling
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] d);
    reset = r;
    req   = rq;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = '0;

    vecs[0]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[1]  = mk(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
    vecs[2]  = mk(0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1, 0);
    vecs[3]  = mk(0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 1, 0);
    vecs[4]  = mk(0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0);
    vecs[5]  = mk(0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 1, 0);
    vecs[6]  = mk(0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    vecs[7]  = mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    vecs[8]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[9]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
    vecs[10] = mk(0, 4'b1111, 4'b1011, 4'b0100, 2'd2, 1, 0);
    vecs[11] = mk(0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0);
    vecs[12] = mk(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, 0);
    vecs[13] = mk(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    vecs[14] = mk(0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1, 0);
    vecs[15] = mk(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 1, 0);
    vecs[16] = mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    vecs[17] = mk(0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 0, 0);
    vecs[18] = mk(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    vecs[19] = mk(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done);
      check_all("vec", i, vecs[i].g, vecs[i].id, vecs[i].b, vecs[i].t);
    end

    // Lone requester held with no done: hold limit (if built) then re-grant after a gap
    step(1, 4'b0000, 4'b0000);
    check_all("hold_rst", 0, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 4'b0001, 4'b0000);
      check_all("hold", i, 4'b0001, 2'd0, 1, 0);
    end
`ifdef LOCK_ARB_TIMEOUT_EN
    step(0, 4'b0001, 4'b0000);
    check_all("forced_rel", 0, 4'b0000, 2'd0, 0, 1);
    step(0, 4'b0001, 4'b0000);
    check_all("regrant", 0, 4'b0001, 2'd0, 1, 0);
`else
    for (int i = 0; i < 17; i++) begin
      step(0, 4'b0001, 4'b0000);
      check_all("hold_long", i, 4'b0001, 2'd0, 1, 0);
    end
`endif

    // done coinciding with the last permitted hold cycle releases without a timeout pulse
    for (int i = 0; i < 7; i++) begin
      step(0, 4'b0001, 4'b0000);
      check_all("hold2", i, 4'b0001, 2'd0, 1, 0);
    end
    step(0, 4'b0001, 4'b0001);
    check_all("done_at_limit", 0, 4'b0000, 2'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
